bus_seq_executor: RTL

BUS_SEQ_EXECUTOR -- requirements
Module: bus_seq_executor

---
 rtl/protocol_sequncer_pkg.sv | 61 ++++++
 rtl/bus_seq_cycle_timer.sv | 37 +++
 rtl/bus_seq_executor.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/protocol_sequncer_pkg.sv
// Shared types for the bus sequence executor: 13-bit program word layout,
// command/instruction encodings and the executor state enum.
package protocol_sequncer_pkg;

    typedef enum logic {
        RUN_TRANSFER = 1'b0,
        RUN_INSTR    = 1'b1
    } cmd_t;

    typedef enum logic [2:0] {
        INSTR_WAIT       = 3'd0,
        INSTR_COMPARE    = 3'd1,
        INSTR_COMP_JMP   = 3'd2,
        INSTR_UNCOND_JMP = 3'd3,
        INSTR_PAUSE      = 3'd4,
        INSTR_STOP       = 3'd5,
        INSTR_UNUSED1    = 3'd6,
        INSTR_UNUSED2    = 3'd7
    } instr_t;

    typedef enum logic {
        COMPARE_LAST     = 1'b0,
        COMPARE_NOT_LAST = 1'b1
    } instr_compare_conf_t;

    typedef enum logic {
        JUMP_DOWN = 1'b0,
        JUMP_UP   = 1'b1
    } instr_jmp_config_t;

    // Transfer word: [12] cmd, [11:8] bus config, [7:0] payload
    typedef struct packed {
        cmd_t       cmd;
        logic [3:0] cnfg;
        logic [7:0] data;
    } xfer_word_t;

    // Instruction word: [12] cmd, [11:9] opcode, [8] compare/jump config, [7:0] operand
    typedef struct packed {
        cmd_t       cmd;
        instr_t     instr;
        logic       cfg;
        logic [7:0] data;
    } instr_word_t;

    typedef union packed {
        xfer_word_t  xfer;
        instr_word_t instr;
    } word_ut;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        XFER_REQ  = 3'd3,
        XFER_WAIT = 3'd4,
        WAIT_CNT  = 3'd5,
        PAUSED    = 3'd6
    } exec_state_t;

endpackage

// File: rtl/bus_seq_cycle_timer.sv
// Down-counting cycle timer shared by WAIT instructions and the transfer
// timeout. expired is high during the last counted cycle (count <= 1).
module bus_seq_cycle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load has priority; counting saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/bus_seq_executor.sv
// Bus sequence executor: fetches 13-bit words from a synchronous program
// memory and runs bus transfers, waits, compares, jumps and pauses.
// Optional feature macro: BUS_SEQ_XFER_TIMEOUT_EN (transfer timeout).
module bus_seq_executor
    import protocol_sequncer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_PRESC  = 100,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              resume,
    output logic              busy,
    output logic              paused,
    output logic              done,
    output logic              error,
    output logic              cmp_flag,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  word_ut            mem_rdata,
    output logic              xfer_valid,
    input  logic              xfer_ready,
    output logic [3:0]        xfer_cnfg,
    output logic [7:0]        xfer_data,
    input  logic              xfer_done,
    input  logic [7:0]        xfer_rx_data
);

    // Timer wide enough for the longest WAIT and for the timeout load value
    localparam int WAIT_MAX = 255 * WAIT_PRESC;
    localparam int WAIT_BW  = $clog2(WAIT_MAX + 1);
    localparam int TOUT_BW  = $clog2(TIMEOUT_CYC + 1);
    localparam int TMR_W    = (WAIT_BW > TOUT_BW) ? WAIT_BW : TOUT_BW;

    exec_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [7:0]          last_rx_q, last_rx_d;
    logic                cmp_q, cmp_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic [3:0]          cnfg_q, cnfg_d;
    logic [7:0]          data_q, data_d;

    logic                tmr_load;
    logic                tmr_count;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_expired;

    instr_t              op;
    logic [7:0]          op_data;
    instr_compare_conf_t cmp_cfg;
    instr_jmp_config_t   jmp_cfg;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   pc_jmp;
    logic [TMR_W-1:0]    wait_load;

    assign op        = mem_rdata.instr.instr;
    assign op_data   = mem_rdata.instr.data;
    assign cmp_cfg   = instr_compare_conf_t'(mem_rdata.instr.cfg);
    assign jmp_cfg   = instr_jmp_config_t'(mem_rdata.instr.cfg);
    assign pc_inc    = pc_q + ADDR_W'(1);
    // Jump targets wrap naturally modulo 2^ADDR_W
    assign pc_jmp    = (jmp_cfg == JUMP_UP) ? (pc_q - ADDR_W'(op_data))
                                            : (pc_q + ADDR_W'(op_data));
    assign wait_load = TMR_W'(32'(op_data) * 32'(WAIT_PRESC));

    bus_seq_cycle_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .expired  (tmr_expired)
    );

    // Next-state and datapath update for the executor FSM
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        last_rx_d = last_rx_q;
        cmp_d     = cmp_q;
        err_d     = err_q;
        done_d    = 1'b0;
        cnfg_d    = cnfg_q;
        data_d    = data_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_count = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    cmp_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                state_d = DECODE;
            end

            DECODE: begin
                if (mem_rdata.xfer.cmd == RUN_TRANSFER) begin
                    cnfg_d  = mem_rdata.xfer.cnfg;
                    data_d  = mem_rdata.xfer.data;
                    state_d = XFER_REQ;
`ifdef BUS_SEQ_XFER_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYC);
`endif
                end else begin
                    case (op)
                        INSTR_WAIT: begin
                            if (op_data == 8'd0) begin
                                pc_d    = pc_inc;
                                state_d = FETCH;
                            end else begin
                                tmr_load = 1'b1;
                                tmr_val  = wait_load;
                                state_d  = WAIT_CNT;
                            end
                        end
                        INSTR_COMPARE: begin
                            if (cmp_cfg == COMPARE_LAST) begin
                                cmp_d = (last_rx_q == op_data);
                            end else begin
                                cmp_d = (last_rx_q != op_data);
                            end
                            pc_d    = pc_inc;
                            state_d = FETCH;
                        end
                        INSTR_COMP_JMP: begin
                            pc_d    = cmp_q ? pc_jmp : pc_inc;
                            state_d = FETCH;
                        end
                        INSTR_UNCOND_JMP: begin
                            pc_d    = pc_jmp;
                            state_d = FETCH;
                        end
                        INSTR_PAUSE: begin
                            state_d = PAUSED;
                        end
                        INSTR_STOP: begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                        default: begin
                            err_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
            end

            XFER_REQ: begin
`ifdef BUS_SEQ_XFER_TIMEOUT_EN
                tmr_count = 1'b1;
`endif
                if (xfer_ready) begin
                    state_d = XFER_WAIT;
                end
`ifdef BUS_SEQ_XFER_TIMEOUT_EN
                else if (tmr_expired) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`endif
            end

            XFER_WAIT: begin
`ifdef BUS_SEQ_XFER_TIMEOUT_EN
                tmr_count = 1'b1;
`endif
                if (xfer_done) begin
                    last_rx_d = xfer_rx_data;
                    pc_d      = pc_inc;
                    state_d   = FETCH;
                end
`ifdef BUS_SEQ_XFER_TIMEOUT_EN
                else if (tmr_expired) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`endif
            end

            WAIT_CNT: begin
                tmr_count = 1'b1;
                if (tmr_expired) begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end

            PAUSED: begin
                if (resume) begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            last_rx_q <= '0;
            cmp_q     <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            cnfg_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            last_rx_q <= last_rx_d;
            cmp_q     <= cmp_d;
            err_q     <= err_d;
            done_q    <= done_d;
            cnfg_q    <= cnfg_d;
            data_q    <= data_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign paused     = (state_q == PAUSED);
    assign done       = done_q;
    assign error      = err_q;
    assign cmp_flag   = cmp_q;
    assign mem_rd_en  = (state_q == FETCH);
    assign mem_addr   = pc_q;
    assign xfer_valid = (state_q == XFER_REQ);
    assign xfer_cnfg  = cnfg_q;
    assign xfer_data  = data_q;

endmodule
